ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 154 +++++++++++++++
 tb/tb_ifetch_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: credit-limited fetch into a DEPTH-entry FIFO with redirect/drain handling.
// Define IFETCH_MISALIGN_CHK_EN to add the fetch_fault output for misaligned redirect targets.

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DepthLim = (CW+1)'(DEPTH);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     respPc_q, respPc_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q;
  logic [CW-1:0]   outCnt_q, outCnt_d;
  logic [CW-1:0]   staleCnt_q, staleCnt_d;
  logic [CW-1:0]   fifoCnt_q, fifoCnt_d;
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [31:0]     memPc_q    [DEPTH];
  logic [31:0]     memInstr_q [DEPTH];
  logic [CW:0]     reqSum;
  logic            grant, push, pop, outValidInt;
  logic [31:0]     redirectTgt;
  logic            fault_d, faultActive;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fault_q;

  assign redirectTgt = redirect_pc;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign faultActive = fault_q;
  assign fetch_fault = fault_q;
`else
  logic unusedRedirectLsb;

  assign redirectTgt       = {redirect_pc[31:2], 2'b00};
  assign unusedRedirectLsb = ^redirect_pc[1:0];
  assign fault_d           = 1'b0;
  assign faultActive       = 1'b0;
`endif

  assign outValidInt = (fifoCnt_q != '0) && !faultActive;
  assign out_valid   = outValidInt;
  assign out_pc      = outValidInt ? memPc_q[rdPtr_q]    : '0;
  assign out_instr   = outValidInt ? memInstr_q[rdPtr_q] : '0;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;

  // A redirect turns every granted-but-unreturned request stale; responses arrive in order,
  // so stale ones always precede the first response to the new target.
  always_comb begin
    grant    = req_q & imem_gnt;
    push     = imem_rvalid && !redirect_valid && (staleCnt_q == '0);
    pop      = outValidInt && out_ready && !redirect_valid;
    outCnt_d = outCnt_q + CW'(grant) - CW'(imem_rvalid);
    if (redirect_valid)                          staleCnt_d = outCnt_d;
    else if (imem_rvalid && staleCnt_q != '0)    staleCnt_d = staleCnt_q - CW'(1);
    else                                         staleCnt_d = staleCnt_q;
    fifoCnt_d = redirect_valid ? '0 : fifoCnt_q + CW'(push) - CW'(pop);
    if (redirect_valid) pc_d = redirectTgt;
    else if (grant)     pc_d = pc_q + 32'd4;
    else                pc_d = pc_q;
    if (redirect_valid) respPc_d = redirectTgt;
    else if (push)      respPc_d = respPc_q + 32'd4;
    else                respPc_d = respPc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)                              state_d = (staleCnt_d != '0) ? DRAIN : FETCH;
    else if (state_q == DRAIN && staleCnt_d == '0)   state_d = FETCH;
  end

  // Requests are limited by credit: queued entries plus in-flight requests never exceed DEPTH.
  always_comb begin
    reqSum = {1'b0, fifoCnt_d} + {1'b0, outCnt_d};
    req_d  = (state_d == FETCH) && !fault_d && (reqSum < DepthLim);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      respPc_q   <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      outCnt_q   <= '0;
      staleCnt_q <= '0;
      fifoCnt_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      respPc_q   <= respPc_d;
      req_q      <= req_d;
      addr_q     <= pc_d;
      outCnt_q   <= outCnt_d;
      staleCnt_q <= staleCnt_d;
      fifoCnt_q  <= fifoCnt_d;
      if (redirect_valid) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + PW'(1);
        if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      memPc_q[wrPtr_q]    <= respPc_q;
      memInstr_q[wrPtr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases push expected PCs, a monitor checks every handshake.
// Also exercises fetch_fault when IFETCH_MISALIGN_CHK_EN is defined.

module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          lat = 1;
  int          grantCnt = 0;
  int          g0;
  logic        gntEn;
  logic [31:0] expQ[$];
  pend_t       pendQ[$];
  logic [31:0] aPc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic rdy, input logic gnt);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    gntEn          = gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory model: in-order responses 'lat' cycles after each grant.
  initial begin
    pend_t p;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (reset) begin
        pendQ.delete();
        imem_gnt = 1'b0;
      end else begin
        if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instrOf(pendQ[0].addr);
          void'(pendQ.pop_front());
        end
        imem_gnt = gntEn;
        if (imem_req && gntEn) begin
          p.addr = imem_addr;
          p.due  = cyc + lat;
          pendQ.push_back(p);
          grantCnt++;
        end
      end
    end
  end

  // Monitor: every accepted output must match the next expected PC; redirect cancels a handshake.
  initial begin
    logic [31:0] expPc;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected output: got pc %h, required no output", out_pc);
        end else begin
          expPc = expQ.pop_front();
          checkOutput("out_pc", out_pc, expPc);
          checkOutput("out_instr", out_instr, instrOf(expPc));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0; gntEn = 1'b0;
    @(posedge clk);
    #1;
    resetDut();
    checkOutput("reset imem_req", 32'(imem_req), 32'h0);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);

    // Streaming from reset: out_pc 0,4,8,12 on cycles 3..6.
    foreach (aPc[i]) expQ.push_back(aPc[i]);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (c == 0) begin
        checkOutput("first imem_req", 32'(imem_req), 32'h1);
        checkOutput("first imem_addr", imem_addr, 32'h0);
      end
      if (c == 1) checkOutput("cycle2 out_valid", 32'(out_valid), 32'h0);
      if (c >= 2 && c <= 5) begin
        checkOutput("stream out_valid", 32'(out_valid), 32'h1);
        checkOutput("stream out_pc", out_pc, aPc[c-2]);
      end
    end

    // Back-pressure: stalled grants hold the request, then the queue fills with 4 grants.
    resetDut();
    checkOutput("reset2 imem_req", 32'(imem_req), 32'h0);
    checkOutput("reset2 out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset2 out_pc", out_pc, 32'h0);
    checkOutput("reset2 out_instr", out_instr, 32'h0);
    g0 = grantCnt;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, (c >= 4));
      if (c == 1 || c == 2) begin
        checkOutput("stall imem_req", 32'(imem_req), 32'h1);
        checkOutput("stall imem_addr", imem_addr, 32'h0);
      end
    end
    checkOutput("full grant count", grantCnt - g0, 32'd4);
    checkOutput("full imem_req", 32'(imem_req), 32'h0);
    checkOutput("full out_valid", 32'(out_valid), 32'h1);
    checkOutput("full out_pc", out_pc, 32'h0);
    checkOutput("full out_instr", out_instr, instrOf(32'h0));
    for (int i = 0; i < 6; i++) expQ.push_back(32'(i * 4));
    for (int c = 16; c < 22; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (c == 19) checkOutput("refill out_pc", out_pc, 32'h10);
    end

    // Redirect with two outstanding requests drains both stale responses.
    resetDut();
    lat = 3;
    expQ.push_back(32'h100);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, (c == 2), 32'h100, 1'b1, 1'b1);
      if (c >= 2 && c <= 4) checkOutput("drain imem_req", 32'(imem_req), 32'h0);
      if (c >= 2 && c <= 8) checkOutput("drain out_valid", 32'(out_valid), 32'h0);
      if (c == 5) begin
        checkOutput("post-drain imem_req", 32'(imem_req), 32'h1);
        checkOutput("post-drain imem_addr", imem_addr, 32'h100);
      end
      if (c == 9) checkOutput("post-drain out_pc", out_pc, 32'h100);
    end

    // Redirect coinciding with rvalid and an output handshake.
    resetDut();
    lat = 1;
    expQ.push_back(32'h0);
    expQ.push_back(32'h40);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b0, (c == 4), 32'h40, 1'b1, 1'b1);
      if (c == 3) checkOutput("pre-redirect out_pc", out_pc, 32'h4);
      if (c == 4 || c == 6) checkOutput("post-redirect out_valid", 32'(out_valid), 32'h0);
      if (c == 4) checkOutput("post-redirect imem_req", 32'(imem_req), 32'h0);
      if (c == 5) checkOutput("coincident imem_addr", imem_addr, 32'h40);
      if (c == 7) checkOutput("coincident out_pc", out_pc, 32'h40);
    end

    // Fetch address wrap at the top of the address space.
    resetDut();
    expQ.push_back(32'hFFFF_FFF8);
    expQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(32'h0000_0000);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c == 0), 32'hFFFF_FFF8, 1'b1, 1'b1);
      if (c == 0) checkOutput("wrap first addr", imem_addr, 32'hFFFF_FFF8);
      if (c == 2) checkOutput("wrap imem_addr", imem_addr, 32'h0);
      if (c == 4) checkOutput("wrap out_pc", out_pc, 32'h0);
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    // Misaligned redirect raises fetch_fault and stops fetching until an aligned redirect.
    resetDut();
    checkOutput("reset fetch_fault", 32'(fetch_fault), 32'h0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, (c == 0 || c == 4), (c == 0) ? 32'h102 : 32'h200, 1'b0, 1'b1);
      if (c <= 3) begin
        checkOutput("fault fetch_fault", 32'(fetch_fault), 32'h1);
        checkOutput("fault imem_req", 32'(imem_req), 32'h0);
        checkOutput("fault out_valid", 32'(out_valid), 32'h0);
      end
      if (c == 4) begin
        checkOutput("clear fetch_fault", 32'(fetch_fault), 32'h0);
        checkOutput("clear imem_req", 32'(imem_req), 32'h1);
        checkOutput("clear imem_addr", imem_addr, 32'h200);
      end
    end
`else
    // Low redirect bits are ignored: 0x106 fetches from 0x104.
    resetDut();
    expQ.push_back(32'h104);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, (c == 0), 32'h106, 1'b1, 1'b1);
      if (c == 0) checkOutput("aligned imem_addr", imem_addr, 32'h104);
      if (c == 2) checkOutput("aligned out_pc", out_pc, 32'h104);
    end
`endif

    resetDut();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
